// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the helper that derives line/frame totals.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned FC_W  = 16;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF,
                                                 H_BACK_DEF);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF,
                                                 V_BACK_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with visible-region and sync-pulse decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned FRONT   = H_FRONT_DEF,
    parameter int unsigned SYNC    = H_SYNC_DEF,
    parameter int unsigned BACK    = H_BACK_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync_active
);

    localparam int unsigned      TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS     = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + CNT_W'(1);
        end
    end

    assign count       = r_count;
    assign wrap        = en && (r_count == LAST);
    assign active      = (r_count < VIS);
    assign sync_active = (r_count >= SYNC_LO) && (r_count <= SYNC_HI);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel strobe divider, row/col counters, registered blanked colour and sync.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             pix_en,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             visible,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    output logic             vga_r,
    output logic             vga_g,
    output logic             vga_b,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick,
    output logic [FC_W-1:0]  frame_count
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_pix_en;
    logic             w_h_wrap, w_h_active, w_h_sync;
    logic             w_v_wrap, w_v_active, w_v_sync;
    logic [2:0]       r_rgb;
    logic             r_hsync, r_vsync;
    logic [FC_W-1:0]  r_frame_count;
    logic [FC_W-1:0]  w_frame_count_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    // Gated by RST so the strobe stays low in reset even when CLK_DIV=1.
    assign w_pix_en = !RST && (r_div_cnt == DIV_LAST);

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .CLK         (CLK),
        .RST         (RST),
        .en          (w_pix_en),
        .count       (col),
        .wrap        (w_h_wrap),
        .active      (w_h_active),
        .sync_active (w_h_sync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .CLK         (CLK),
        .RST         (RST),
        .en          (w_h_wrap),
        .count       (row),
        .wrap        (w_v_wrap),
        .active      (w_v_active),
        .sync_active (w_v_sync)
    );

    assign visible    = w_h_active && w_v_active;
    assign frame_tick = w_v_wrap;

    // Colour and sync share one register stage so they stay pixel-aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rgb   <= 3'b000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_en) begin
            r_rgb   <= visible ? {red_in, green_in, blue_in} : 3'b000;
            r_hsync <= !w_h_sync;
            r_vsync <= !w_v_sync;
        end
    end

    always_comb begin
        w_frame_count_d = r_frame_count;
        if (frame_tick) begin
            w_frame_count_d = r_frame_count + FC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_count <= '0;
        end else begin
            r_frame_count <= w_frame_count_d;
        end
    end

    assign pix_en      = w_pix_en;
    assign vga_r       = r_rgb[2];
    assign vga_g       = r_rgb[1];
    assign vga_b       = r_rgb[0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing.sv
// Randomised bench for vga_timing on a shrunken raster, checked against an arithmetic raster model.
module tb_vga_timing;

    localparam int unsigned HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned DIV = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
    logic        pix_en, visible, vga_r, vga_g, vga_b, hsync, vsync, frame_tick;
    logic [9:0]  row, col;
    logic [15:0] frame_count;
    logic        pix_en_1, visible_1, vga_r_1, vga_g_1, vga_b_1, hsync_1, vsync_1, frame_tick_1;
    logic [9:0]  row_1, col_1;
    logic [15:0] frame_count_1;

    always #5 CLK = ~CLK;

    vga_timing #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .CLK_DIV   (DIV)
    ) dut (
        .CLK (CLK), .RST (RST), .pix_en (pix_en), .row (row), .col (col), .visible (visible),
        .red_in (red_in), .green_in (green_in), .blue_in (blue_in),
        .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b), .hsync (hsync), .vsync (vsync),
        .frame_tick (frame_tick), .frame_count (frame_count)
    );

    vga_timing #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .CLK_DIV   (1)
    ) dut_div1 (
        .CLK (CLK), .RST (RST), .pix_en (pix_en_1), .row (row_1), .col (col_1),
        .visible (visible_1), .red_in (red_in), .green_in (green_in), .blue_in (blue_in),
        .vga_r (vga_r_1), .vga_g (vga_g_1), .vga_b (vga_b_1), .hsync (hsync_1),
        .vsync (vsync_1), .frame_tick (frame_tick_1), .frame_count (frame_count_1)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model: m_c = clock edges since the last reset edge; pixel index = m_c / DIV.
    int unsigned m_c = 0;
    bit          m_valid = 1'b0;
    bit          m_check = 1'b1;
    logic [2:0]  m_rgb = 3'b000;
    logic        m_hs = 1'b1, m_vs = 1'b1;

    bit          stats_on = 1'b0;
    bit          all_ones = 1'b0;
    int unsigned h_low_cnt = 0, rgb_on_cnt = 0, v_low_lines = 0;
    int unsigned h_first_col = 0, v_first_row = 0;
    int unsigned tick_c[$];
    int unsigned tick_pos[$];

    function automatic bit in_sync(input int unsigned p, input int unsigned vis,
                                   input int unsigned fr, input int unsigned sw);
        return (p >= vis + fr) && (p < vis + fr + sw);
    endfunction

    task automatic step(input logic rst_v);
        int unsigned n, mcol, mrow;
        bit          pe;
        n    = m_c / DIV;
        mcol = n % HT;
        mrow = (n / HT) % VT;
        pe   = !RST && (m_c % DIV == DIV - 1);
        if (m_valid && m_check) begin
            check("pix_en", 32'(pix_en), 32'(pe));
            check("col", 32'(col), mcol);
            check("row", 32'(row), mrow);
            check("visible", 32'(visible), 32'(mcol < HV && mrow < VV));
            check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb));
            check("hsync", 32'(hsync), 32'(m_hs));
            check("vsync", 32'(vsync), 32'(m_vs));
            check("frame_tick", 32'(frame_tick), 32'(pe && mrow == VT - 1 && mcol == HT - 1));
            check("frame_count", 32'(frame_count), (n / FRAME) % 65536);
            check("div1_pix_en", 32'(pix_en_1), 32'(!RST));
            check("div1_col", 32'(col_1), RST ? 0 : m_c % HT);
        end
        if (m_valid && stats_on && !RST) begin
            if (pe && n >= 2 * HT && n < 3 * HT) begin
                if (hsync == 1'b0) begin
                    if (h_low_cnt == 0) h_first_col = 32'(col);
                    h_low_cnt++;
                end
                if ({vga_r, vga_g, vga_b} == 3'b111) rgb_on_cnt++;
            end
            if (pe && n < FRAME && mcol == 1 && vsync == 1'b0) begin
                if (v_low_lines == 0) v_first_row = 32'(row);
                v_low_lines++;
            end
            if (frame_tick === 1'b1) begin
                tick_c.push_back(m_c);
                tick_pos.push_back(32'(row) * 1024 + 32'(col));
            end
        end
        RST = rst_v;
        {red_in, green_in, blue_in} = all_ones ? 3'b111 : 3'($urandom);
        if (rst_v) begin
            m_c     = 0;
            m_rgb   = 3'b000;
            m_hs    = 1'b1;
            m_vs    = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_c % DIV == DIV - 1) begin
                m_rgb = (mcol < HV && mrow < VV) ? {red_in, green_in, blue_in} : 3'b000;
                m_hs  = !in_sync(mcol, HV, HF, HS);
                m_vs  = !in_sync(mrow, VV, VF, VS);
            end
            m_c++;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int unsigned i;
        @(negedge CLK);
        repeat (3) step(1'b1);

        // Three frames; the first with all colour inputs held high.
        stats_on = 1'b1;
        for (int k = 0; k < 3 * FRAME * DIV + 10; k++) begin
            all_ones = (m_c < FRAME * DIV);
            step(1'b0);
        end
        stats_on = 1'b0;
        all_ones = 1'b0;
        check("h_low_pixels", h_low_cnt, HS);
        check("h_first_low_col", h_first_col, HV + HF + 1);
        check("rgb_on_pixels", rgb_on_cnt, HV);
        check("v_low_lines", v_low_lines, VS);
        check("v_first_low_row", v_first_row, VV + VF);
        check("tick_count", tick_c.size(), 3);
        if (tick_c.size() == 3) begin
            check("tick0_time", tick_c[0], FRAME * DIV - 1);
            check("tick_gap01", tick_c[1] - tick_c[0], FRAME * DIV);
            check("tick_gap12", tick_c[2] - tick_c[1], FRAME * DIV);
            for (int k = 0; k < 3; k++) check("tick_pos", tick_pos[k], (VT - 1) * 1024 + HT - 1);
        end
        check("frames_after_3", 32'(frame_count), 3);

        // Mid-frame reset at (5,7).
        i = 0;
        while (i < 4 * FRAME * DIV && !(((m_c / DIV) / HT) % VT == 5 && (m_c / DIV) % HT == 7)) begin
            step(1'b0);
            i++;
        end
        check("seek_mid_frame", 32'(row) * 1024 + 32'(col), 5 * 1024 + 7);
        step(1'b1);
        check("mid_rst_row", 32'(row), 0);
        check("mid_rst_col", 32'(col), 0);
        check("mid_rst_sync", 32'({hsync, vsync}), 3);
        check("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        check("mid_rst_fc", 32'(frame_count), 0);
        for (int k = 0; k < 60; k++) step(1'b0);

        // Frame counter wrap from 65535.
        step(1'b1);
        while (m_c < 2 * (FRAME - 1)) step(1'b0);
        m_check = 1'b0;
        force dut.r_frame_count = 16'hffff;
        step(1'b0);
        check("wrap_tick_high", 32'(frame_tick), 1);
        check("wrap_pre_count", 32'(frame_count), 32'hffff);
        check("wrap_pos", 32'(row) * 1024 + 32'(col), (VT - 1) * 1024 + HT - 1);
        release dut.r_frame_count;
        step(1'b0);
        check("wrap_post_count", 32'(frame_count), 0);
        check("wrap_post_pos", 32'(row) * 1024 + 32'(col), 0);
        step(1'b1);
        m_check = 1'b1;
        repeat (4) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
